strand_issue_arbiter: RTL and testbench

- Selects which hardware strand issues an instruction each cycle.
- Eligibility per strand = enabled (strand_enable from the control-register block) AND instruction ready AND not suspended.
- Fair round-robin among eligible strands; tracks per-strand suspend state for cache-miss/rollback waits.
- Sits between the per-strand instruction FIFOs and the decode stage; the registered issue strand drives ex_strand downstream.

---
 rtl/strand_issue_arbiter_if.sv | 27 ++
 rtl/strand_issue_arbiter.sv | 83 ++++++++
 tb/tb_strand_issue_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/strand_issue_arbiter_if.sv
// strand_issue_arbiter_if
//   Bundles the per-strand status/control inputs and the registered issue
//   outputs of the strand issue arbiter.
//   master : drives enables, ready, suspend/resume pulses and stall;
//            observes the issue outputs and suspend bits.
//   slave  : the arbiter itself.
interface strand_issue_arbiter_if;
    logic [3:0] strand_enable;
    logic [3:0] strand_ready;
    logic [3:0] suspend_strand;
    logic [3:0] resume_strand;
    logic       issue_stall;
    logic       issue_valid;
    logic [1:0] issue_strand;
    logic [3:0] issue_grant_oh;
    logic [3:0] suspended;

    modport master (
        output strand_enable, strand_ready, suspend_strand, resume_strand, issue_stall,
        input  issue_valid, issue_strand, issue_grant_oh, suspended
    );

    modport slave (
        input  strand_enable, strand_ready, suspend_strand, resume_strand, issue_stall,
        output issue_valid, issue_strand, issue_grant_oh, suspended
    );
endinterface

// File: rtl/strand_issue_arbiter.sv
// strand_issue_arbiter
//   Picks one of four hardware strands to issue each cycle using a fair
//   round-robin over eligible strands (enabled, ready, not suspended), and
//   keeps the per-strand suspend state used for cache-miss/rollback waits.
// Ports
//   clk    : core clock
//   reset  : asynchronous, active-high reset
//   bus    : strand_issue_arbiter_if.slave
//            in  strand_enable[3:0], strand_ready[3:0], suspend_strand[3:0],
//                resume_strand[3:0], issue_stall
//            out issue_valid, issue_strand[1:0], issue_grant_oh[3:0],
//                suspended[3:0] (all registered)
module strand_issue_arbiter #(
    parameter int NUM_STRANDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    strand_issue_arbiter_if.slave  bus
);

    logic [3:0] suspended_q;
    logic       issue_valid_q;
    logic [1:0] issue_strand_q;
    logic [3:0] issue_grant_oh_q;
    logic [1:0] rr_pointer;

    logic [3:0] eligible;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;

    // Selection sees registered suspend bits only; this cycle's
    // suspend/resume pulses take effect on the next selection.
    assign eligible = bus.strand_enable & bus.strand_ready & ~suspended_q;

    // Scan from the far end back toward rr_pointer so the nearest eligible
    // strand (first in ascending, wrapping order) is the last assignment.
    always_comb begin
        found  = 1'b0;
        winner = rr_pointer;
        idx    = rr_pointer;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_pointer + 2'(k);
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            suspended_q      <= 4'b0000;
            issue_valid_q    <= 1'b0;
            issue_strand_q   <= 2'd0;
            issue_grant_oh_q <= 4'b0000;
            rr_pointer       <= 2'd0;
        end else begin
            // Suspend wins over a simultaneous resume.
            suspended_q <= (suspended_q & ~bus.resume_strand) | bus.suspend_strand;

            // Under stall the held grant stays valid regardless of what
            // happens to its strand: its instruction is already dequeued.
            if (!bus.issue_stall) begin
                if (found) begin
                    issue_valid_q    <= 1'b1;
                    issue_strand_q   <= winner;
                    issue_grant_oh_q <= 4'b0001 << winner;
                    rr_pointer       <= winner + 2'd1;
                end else begin
                    issue_valid_q    <= 1'b0;
                    issue_grant_oh_q <= 4'b0000;
                end
            end
        end
    end

    assign bus.issue_valid    = issue_valid_q;
    assign bus.issue_strand   = issue_strand_q;
    assign bus.issue_grant_oh = issue_grant_oh_q;
    assign bus.suspended      = suspended_q;

endmodule

// File: tb/tb_strand_issue_arbiter.sv
module tb_strand_issue_arbiter;

    logic clk;
    logic reset;

    strand_issue_arbiter_if bus ();

    strand_issue_arbiter #(.NUM_STRANDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] rdy;
        logic [3:0] sus;
        logic [3:0] res;
        logic       stall;
        logic       exp_valid;
        logic [1:0] exp_strand;
        logic [3:0] exp_susp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic [3:0] rdy, input logic [3:0] sus,
                       input logic [3:0] res, input logic stall, input logic ev,
                       input logic [1:0] es, input logic [3:0] esusp);
        vec_t v;
        v.en = en; v.rdy = rdy; v.sus = sus; v.res = res; v.stall = stall;
        v.exp_valid = ev; v.exp_strand = es; v.exp_susp = esusp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] rdy, input logic [3:0] sus,
                         input logic [3:0] res, input logic stall);
        bus.strand_enable  = en;
        bus.strand_ready   = rdy;
        bus.suspend_strand = sus;
        bus.resume_strand  = res;
        bus.issue_stall    = stall;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [1:0] es,
                                 input logic [3:0] esusp);
        logic [3:0] eoh;
        eoh = ev ? (4'b0001 << es) : 4'b0000;
        chk({tag, " valid"},  32'(bus.issue_valid),    32'(ev));
        chk({tag, " strand"}, 32'(bus.issue_strand),   32'(es));
        chk({tag, " oh"},     32'(bus.issue_grant_oh), 32'(eoh));
        chk({tag, " susp"},   32'(bus.suspended),      32'(esusp));
    endtask

    // Grant one-hot must always agree with valid/strand.
    always @(negedge clk) begin
        chk("invariant_oh", 32'(bus.issue_grant_oh),
            32'(bus.issue_valid ? (4'b0001 << bus.issue_strand) : 4'b0000));
    end

    initial begin
        // all strands round robin
        for (int k = 0; k < 8; k++) add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'(k % 4), 4'h0);
        // enable 0101: alternate 0,2
        add(4'h5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0);
        add(4'h5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 4'h0);
        add(4'h5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0);
        add(4'h5, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 4'h0);
        // stall holding grant 2 while strand 2 is disabled
        for (int k = 0; k < 3; k++) add(4'hB, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'h0);
        add(4'hB, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0);
        add(4'hB, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0);
        add(4'hB, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h0);
        add(4'hB, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0);
        // suspend strand 1 (no ready that cycle: pointer stays at 0)
        add(4'hF, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 2'd3, 4'h2);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h2);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, 4'h2);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h2);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h2);
        // resume strand 1: same-cycle selection still skips it
        add(4'hF, 4'hF, 4'h0, 4'h2, 1'b0, 1'b1, 2'd2, 4'h0);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h0);
        // simultaneous suspend+resume on strand 3: suspend wins
        add(4'hF, 4'hF, 4'h8, 4'h8, 1'b0, 1'b1, 2'd2, 4'h8);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h8);
        add(4'hF, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 2'd0, 4'h0);
        // all halted, none ready, single ready strand back to back
        add(4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        add(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        add(4'hF, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0);
        add(4'hF, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0);
        // set up suspended=0110 with a valid grant
        add(4'hF, 4'hF, 4'h6, 4'h0, 1'b0, 1'b1, 2'd0, 4'h6);
        add(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h6);

        reset = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 2'd0, 4'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].sus, vecs[i].res, vecs[i].stall);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_strand,
                          vecs[i].exp_susp);
        end

        // Async reset mid-stream, between clock edges.
        chk("pre_reset valid", 32'(bus.issue_valid), 32'd1);
        chk("pre_reset susp",  32'(bus.suspended),   32'h6);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 2'd0, 4'h0);
        @(posedge clk);
        #1;
        check_outputs("reset_held", 1'b0, 2'd0, 4'h0);
        reset = 1'b0;

        // Search restarts from strand 0.
        drive(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("post_reset0", 1'b1, 2'd0, 4'h0);
        @(posedge clk);
        #1;
        check_outputs("post_reset1", 1'b1, 2'd1, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
